// File: rtl/bmult_cpa_pipe.sv
// bmult_cpa_pipe: segmented carry-propagate adder for the Bmult family.
// Adds the two reduced rows coming out of the bit-heap compressor, resolving SEG
// bits per pipeline stage. Valid/ready on both sides, with per-stage bubble
// collapsing. Results leave in acceptance order and carry their sideband tag.
module bmult_cpa_pipe #(
  parameter int W     = 41,
  parameter int OUT_W = 40,
  parameter int SEG   = 11,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_row0,
  input  logic [W-1:0]     in_row1,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_p,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf
);

  localparam int NSEG = (W + SEG - 1) / SEG;
  // Rows are zero-padded to a whole number of segments. Above bit W-1 the padded
  // sum then holds the carry out of the W-bit addition, so every stage can use the
  // same SEG-bit adder.
  localparam int PW = NSEG * SEG;

  typedef struct packed {
    logic             v;    // stage holds a live operation
    logic [TAG_W-1:0] tag;  // sideband travelling with the operation
    logic [PW-1:0]    sum;  // resolved sum bits of segments 0..k
    logic             c;    // carry out of segment k
    logic [PW-1:0]    r0;   // raw row 0; segments above k are still unresolved
    logic [PW-1:0]    r1;   // raw row 1; segments above k are still unresolved
  } stage_t;

  stage_t            stg_q [NSEG];
  stage_t            stg_d [NSEG];
  logic   [NSEG-1:0] adv;

  // Advance chain, computed from the output back to the input. A stage moves
  // when it is empty or when its successor moves, so bubbles collapse.
  always_comb begin
    adv            = '0;
    adv[NSEG-1]    = ~stg_q[NSEG-1].v | out_ready;
    for (int k = NSEG - 2; k >= 0; k--) begin
      adv[k] = ~stg_q[k].v | adv[k+1];
    end
  end

  // Candidate contents for each stage: the predecessor's contents (the input
  // for stage 0) with segment k resolved by adding in the incoming carry.
  always_comb begin
    stage_t         src [NSEG];
    logic [SEG:0]   seg;
    // NOTE: every variable gets a default before any conditional or partial
    // write, so that no path leaves one unassigned and no latch is inferred.
    seg = '0;
    for (int k = 0; k < NSEG; k++) begin
      src[k]   = '0;
      stg_d[k] = '0;
    end
    src[0].v   = in_valid;
    src[0].tag = in_tag;
    src[0].r0  = PW'(in_row0);
    src[0].r1  = PW'(in_row1);
    for (int k = 1; k < NSEG; k++) begin
      src[k] = stg_q[k-1];
    end
    for (int k = 0; k < NSEG; k++) begin
      seg = {1'b0, src[k].r0[k*SEG +: SEG]}
          + {1'b0, src[k].r1[k*SEG +: SEG]}
          + {{SEG{1'b0}}, src[k].c};
      stg_d[k]                   = src[k];
      stg_d[k].sum[k*SEG +: SEG] = seg[SEG-1:0];
      stg_d[k].c                 = seg[SEG];
    end
  end

  // Stage registers. The valid bit follows the predecessor on every advance.
  // Data loads only when a live operation arrives, so the last stage (and with
  // it out_*) keeps its value while out_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data fields are reset along with the valid bits because
      // out_p/out_tag/out_ovf come straight from the last stage and must read 0
      // after reset.
      for (int k = 0; k < NSEG; k++) begin
        stg_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSEG; k++) begin
        if (adv[k]) begin
          // NOTE: non-blocking assignments, so every stage samples its
          // predecessor's value from before the clock edge.
          stg_q[k].v <= stg_d[k].v;
          if (stg_d[k].v) begin
            stg_q[k] <= stg_d[k];
          end
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = stg_q[NSEG-1].v;
  assign out_p     = stg_q[NSEG-1].sum[OUT_W-1:0];
  assign out_tag   = stg_q[NSEG-1].tag;
  assign out_ovf   = |{stg_q[NSEG-1].c, stg_q[NSEG-1].sum[PW-1:OUT_W]};

endmodule

// File: tb/tb_bmult_cpa_pipe.sv
// tb_bmult_cpa_pipe: directed scenarios followed by a randomized run, all checked
// against a queue-based arithmetic model of the pipeline.
module tb_bmult_cpa_pipe;

  localparam int W     = 41;
  localparam int OUT_W = 40;
  localparam int TAG_W = 4;
  localparam int LAT   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_row0;
  logic [W-1:0]     in_row1;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_p;
  logic [TAG_W-1:0] out_tag;
  logic             out_ovf;

  bmult_cpa_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row0   (in_row0),
    .in_row1   (in_row1),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_tag   (out_tag),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] p;
    logic [TAG_W-1:0] tag;
    logic             ovf;
  } exp_t;

  exp_t q[$];          // accepted operations whose results have not yet left
  int   pop_log[$];    // cycle numbers at which results were consumed
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc_n    = 0;
  bit   pushed;
  bit   popped;

  // Reference: the full sum as a plain integer, then modulo / threshold.
  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic [TAG_W-1:0] t);
    exp_t        e;
    logic [63:0] s;
    s     = 64'(a) + 64'(b);
    e.p   = OUT_W'(s % (64'd1 << OUT_W));
    e.ovf = (s >= (64'd1 << OUT_W));
    e.tag = t;
    return e;
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock cycle: inputs are already driven; sample handshakes away from the
  // rising edge, score any result leaving, record any accepted operation.
  task automatic cyc();
    exp_t e;
    #1;
    pushed = in_valid && in_ready;
    popped = out_valid && out_ready;
    if (popped) begin
      pop_log.push_back(cyc_n);
      if (q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e = q.pop_front();
        check("out_p", out_p, e.p);
        check("out_tag", out_tag, e.tag);
        check("out_ovf", out_ovf, e.ovf);
      end
    end
    if (pushed) q.push_back(model(in_row0, in_row1, in_tag));
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic drain(int bound);
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() > 0 && n < bound) begin
      cyc();
      n++;
    end
    check("drain_complete", q.size(), 0);
  endtask

  function automatic logic [W-1:0] rand_row();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0:       return '1;                      // all ones
      1:       return W'(64'hFF_FFFF_FFFF);    // 40 ones: carries ripple end to end
      default: return W'(r);
    endcase
  endfunction

  initial begin
    int               lat;
    int               idx;
    int               start;
    int               n;
    logic [OUT_W-1:0] hold_p;
    logic [TAG_W-1:0] hold_tag;
    logic             hold_ovf;
    bit               holding;

    // ---- reset ----
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_row0   = '0;
    in_row1   = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_p", out_p, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_ovf", out_ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    // ---- basic: single op, latency and value ----
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_row0   = 41'h0FF_FFE0_0000;
    in_row1   = 41'h1;
    in_tag    = 4'd3;
    cyc();
    check("basic_accept", pushed, 1);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      cyc();
      lat++;
    end
    check("basic_latency", lat, LAT);
    check("basic_p", out_p, 40'hFF_FFE0_0001);
    check("basic_ovf", out_ovf, 0);
    check("basic_tag", out_tag, 3);
    cyc();

    // ---- full carry ripple across every segment ----
    in_valid = 1'b1;
    in_row0  = 41'h0FF_FFFF_FFFF;
    in_row1  = 41'h1;
    in_tag   = 4'd9;
    cyc();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      cyc();
      lat++;
    end
    check("ripple_p", out_p, 0);
    check("ripple_ovf", out_ovf, 1);
    check("ripple_tag", out_tag, 9);
    drain(20);

    // ---- streaming: 16 back-to-back ops ----
    pop_log.delete();
    start = cyc_n;
    idx   = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_row0  = rand_row();
      in_row1  = rand_row();
      in_tag   = TAG_W'(i);
      cyc();
      if (pushed) idx++;
    end
    check("stream_accepted", idx, 16);
    drain(40);
    check("stream_count", pop_log.size(), 16);
    if (pop_log.size() == 16) begin
      check("stream_first_latency", pop_log[0] - start, LAT);
      check("stream_back_to_back", pop_log[15] - pop_log[0], 15);
    end

    // ---- backpressure: 6 ops offered while the consumer stalls 10 cycles ----
    pop_log.delete();
    out_ready = 1'b0;
    idx       = 0;
    holding   = 1'b0;
    in_row0   = rand_row();
    in_row1   = rand_row();
    for (int i = 0; i < 10; i++) begin
      in_valid = (idx < 6);
      in_tag   = TAG_W'(idx);
      cyc();
      if (pushed) begin
        idx++;
        in_row0 = rand_row();
        in_row1 = rand_row();
      end
      if (out_valid && !holding) begin
        holding  = 1'b1;
        hold_p   = out_p;
        hold_tag = out_tag;
        hold_ovf = out_ovf;
      end else if (holding) begin
        check("stall_p_stable", out_p, hold_p);
        check("stall_tag_stable", out_tag, hold_tag);
        check("stall_ovf_stable", out_ovf, hold_ovf);
      end
    end
    check("stall_accepted", idx, 4);
    #1;
    check("stall_in_ready", in_ready, 0);
    out_ready = 1'b1;
    n = 0;
    while (idx < 6 && n < 20) begin
      in_valid = 1'b1;
      in_tag   = TAG_W'(idx);
      cyc();
      if (pushed) begin
        idx++;
        in_row0 = rand_row();
        in_row1 = rand_row();
      end
      n++;
    end
    drain(40);
    check("stall_results", pop_log.size(), 6);

    // ---- bubbles: op every third cycle under backpressure, then release ----
    pop_log.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      in_valid = (i % 3 == 0);
      in_row0  = rand_row();
      in_row1  = rand_row();
      in_tag   = TAG_W'(8 + i / 3);
      cyc();
      if (i % 3 == 0) check("bubble_accept", pushed, 1);
    end
    drain(20);
    check("bubble_results", pop_log.size(), 4);
    if (pop_log.size() == 4) check("bubble_packed", pop_log[3] - pop_log[0], 3);

    // ---- reset mid-flight discards everything ----
    pop_log.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_row0  = rand_row();
      in_row1  = rand_row() | 41'h1;
      in_tag   = TAG_W'(12 + i);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    cyc();
    check("mid_out_valid_before", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_p", out_p, 0);
    check("mid_rst_out_tag", out_tag, 0);
    check("mid_rst_out_ovf", out_ovf, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    check("mid_no_ghosts", pop_log.size(), 0);

    // ---- random traffic ----
    idx = 0;
    n   = 0;
    while (idx < 10000 && n < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_row0   = rand_row();
      in_row1   = rand_row();
      in_tag    = TAG_W'(idx);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
      if (pushed) idx++;
      n++;
    end
    check("random_accepted", idx, 10000);
    drain(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
